// File: rtl/memory_wrapper_dp_arb.sv
// Dual-port word-addressed SRAM wrapper serving two OBI-style request ports.
// Same-word conflicts involving a write are resolved round-robin; out-of-map accesses get an error response.
module memory_wrapper_dp_arb #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAP_A = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAP_B = '0,
  parameter int unsigned           RD_LAT     = 1,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    data_req_a,
  input  logic [ADDR_WIDTH-1:0]   data_addr_a,
  input  logic                    data_we_a,
  input  logic [DATA_WIDTH/8-1:0] data_be_a,
  input  logic [DATA_WIDTH-1:0]   data_wdata_a,
  output logic                    data_gnt_a,
  output logic                    data_rvalid_a,
  output logic                    data_err_a,
  output logic [DATA_WIDTH-1:0]   data_rdata_a,
  input  logic                    data_req_b,
  input  logic [ADDR_WIDTH-1:0]   data_addr_b,
  input  logic                    data_we_b,
  input  logic [DATA_WIDTH/8-1:0] data_be_b,
  input  logic [DATA_WIDTH-1:0]   data_wdata_b,
  output logic                    data_gnt_b,
  output logic                    data_rvalid_b,
  output logic                    data_err_b,
  output logic [DATA_WIDTH-1:0]   data_rdata_b,
  output logic [CNT_WIDTH-1:0]    conflict_cnt
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int OFF = $clog2(BW);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] idx_a, idx_b;
  logic          in_map_a, in_map_b;
  logic          conflict, prio_b;
  logic          wr_a, wr_b;

  assign idx_a = data_addr_a[AW+OFF-1:OFF];
  assign idx_b = data_addr_b[AW+OFF-1:OFF];

  if (ADDR_WIDTH > AW + OFF) begin : g_map
    assign in_map_a = (data_addr_a[ADDR_WIDTH-1:AW+OFF] == ADDR_MAP_A[ADDR_WIDTH-1:AW+OFF]);
    assign in_map_b = (data_addr_b[ADDR_WIDTH-1:AW+OFF] == ADDR_MAP_B[ADDR_WIDTH-1:AW+OFF]);
  end else begin : g_nomap
    assign in_map_a = 1'b1;
    assign in_map_b = 1'b1;
  end

  if (OFF > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{data_addr_a[OFF-1:0], data_addr_b[OFF-1:0]};
  end

  assign conflict   = data_req_a && data_req_b && in_map_a && in_map_b &&
                      (idx_a == idx_b) && (data_we_a || data_we_b);
  assign data_gnt_a = data_req_a && (!conflict || !prio_b);
  assign data_gnt_b = data_req_b && (!conflict || prio_b);

  assign wr_a = data_gnt_a && data_we_a && in_map_a;
  assign wr_b = data_gnt_b && data_we_b && in_map_b;

  // prio_b = 0 means port A wins the next conflict; the loser takes priority afterwards.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_b       <= 1'b0;
      conflict_cnt <= '0;
    end else if (conflict) begin
      prio_b <= !prio_b;
      if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BW; i++) begin
      if (wr_a && data_be_a[i]) mem[idx_a][i*8 +: 8] <= data_wdata_a[i*8 +: 8];
      if (wr_b && data_be_b[i]) mem[idx_b][i*8 +: 8] <= data_wdata_b[i*8 +: 8];
    end
  end

  logic                  rvalid1_a, rvalid1_b, err1_a, err1_b;
  logic [DATA_WIDTH-1:0] rdata1_a, rdata1_b;

  // Reads sample the array before any write landing on the same edge.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid1_a <= 1'b0;
      rvalid1_b <= 1'b0;
      err1_a    <= 1'b0;
      err1_b    <= 1'b0;
      rdata1_a  <= '0;
      rdata1_b  <= '0;
    end else begin
      rvalid1_a <= data_gnt_a;
      rvalid1_b <= data_gnt_b;
      err1_a    <= data_gnt_a && !in_map_a;
      err1_b    <= data_gnt_b && !in_map_b;
      rdata1_a  <= (data_gnt_a && in_map_a && !data_we_a) ? mem[idx_a] : '0;
      rdata1_b  <= (data_gnt_b && in_map_b && !data_we_b) ? mem[idx_b] : '0;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                  rvalid2_a, rvalid2_b, err2_a, err2_b;
    logic [DATA_WIDTH-1:0] rdata2_a, rdata2_b;

    always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
        rvalid2_a <= 1'b0;
        rvalid2_b <= 1'b0;
        err2_a    <= 1'b0;
        err2_b    <= 1'b0;
        rdata2_a  <= '0;
        rdata2_b  <= '0;
      end else begin
        rvalid2_a <= rvalid1_a;
        rvalid2_b <= rvalid1_b;
        err2_a    <= err1_a;
        err2_b    <= err1_b;
        rdata2_a  <= rdata1_a;
        rdata2_b  <= rdata1_b;
      end
    end

    assign data_rvalid_a = rvalid2_a;
    assign data_rvalid_b = rvalid2_b;
    assign data_err_a    = err2_a;
    assign data_err_b    = err2_b;
    assign data_rdata_a  = rdata2_a;
    assign data_rdata_b  = rdata2_b;
  end else begin : g_lat1
    assign data_rvalid_a = rvalid1_a;
    assign data_rvalid_b = rvalid1_b;
    assign data_err_a    = err1_a;
    assign data_err_b    = err1_b;
    assign data_rdata_a  = rdata1_a;
    assign data_rdata_b  = rdata1_b;
  end

endmodule
